router_pkt_src: RTL and testbench
=================================

ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 SHALL have parameter BUF_AW, default 6, payload buffer address width; buffer holds 2^BUF_AW-1 = 63 bytes; only 6 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pl_wr  input  1  payload byte write strobe.
REQ-005 SHALL have port pl_data  input  8  payload byte written when pl_wr accepted.
REQ-006 SHALL have port load_ready  output  1  payload write accepted this cycle.
REQ-007 SHALL have port start  input  1  launch one packet, sampled in IDLE only.
REQ-008 SHALL have port dest  input  2  destination port, sampled with start.
REQ-009 SHALL have port len  input  6  payload length, sampled with start.
REQ-010 SHALL have port corrupt_parity  input  1  error injection, sampled with start.
REQ-011 SHALL have port busy  input  1  router busy; stalls the byte currently presented.
REQ-012 SHALL have port pkt_valid  output  1  to router pkt_valid.
REQ-013 SHALL have port data_out  output  8  to router data_in.
REQ-014 SHALL have port tx_active  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when parity byte accepted.
REQ-016 SHALL have port start_err  output  1  one-cycle pulse when start rejected.

Function
REQ-017 SHALL form packet: header {len[5:0], dest[1:0]}, then len payload bytes in write order, then parity byte = XOR of header and all payload bytes.
REQ-018 SHALL drive pkt_valid=1 while header and payload bytes are presented and pkt_valid=0 while parity byte is presented.
REQ-019 SHALL treat a presented byte as consumed on a rising edge with busy=0; with busy=1, data_out, pkt_valid and state SHALL hold unchanged.
REQ-020 SHALL implement states IDLE, HEADER, PAYLOAD, PARITY; all outputs registered.
REQ-021 IDLE: pkt_valid=0, data_out=0x00; load_ready = (count < 63); pl_wr with load_ready=1 stores pl_data and increments count; pl_wr otherwise ignored.
REQ-022 IDLE + start: if dest==2'b11 or len > count, SHALL pulse start_err next cycle and remain IDLE; else next cycle HEADER with header on data_out, pkt_valid=1 (1-cycle start-to-header latency).
REQ-023 HEADER consumed -> PAYLOAD with payload byte 0 presented if len>0; -> PARITY if len==0.
REQ-024 PAYLOAD: each consumed byte advances to next buffered byte; after byte len-1 consumed -> PARITY.
REQ-025 PARITY: data_out = computed parity, bit 0 inverted if corrupt_parity was latched; on consumption -> IDLE, done=1 for that one cycle, data_out=0x00.
REQ-026 On return to IDLE SHALL discard any buffered bytes beyond len and reset count and pointers to 0.
REQ-027 start, pl_wr, dest, len, corrupt_parity SHALL be ignored outside IDLE; load_ready=0 outside IDLE.
REQ-028 busy may toggle every cycle; bytes SHALL never be skipped or duplicated.

Reset
REQ-029 resetn=0 SHALL immediately force IDLE, pkt_valid=0, data_out=0x00, done=0, start_err=0, tx_active=0, count=0, pointers=0, parity accumulator=0, regardless of state.
REQ-030 Reset mid-packet SHALL abandon the packet; after release block SHALL accept new loads and start normally.

Verification
REQ-031 Load 01,02,03,04,05; start dest=2 len=5, busy=0 -> data_out 16,01,02,03,04,05 with pkt_valid=1, then 17 with pkt_valid=0, done pulse; 7 cycles start-edge to done.
REQ-032 Same packet, busy=1 for 3 cycles during byte 03 -> 03 held 3 extra cycles, identical byte sequence, done 3 cycles later.
REQ-033 Start dest=1 len=0 with empty buffer -> header 0x01 (pkt_valid=1), parity 0x01 (pkt_valid=0), done.
REQ-034 Load 2 bytes, start len=5 -> start_err pulse, no pkt_valid; start dest=3 len=0 -> start_err pulse.
REQ-035 REQ-031 packet with corrupt_parity=1 -> parity byte 0x16.
REQ-036 Assert resetn=0 while byte 02 presented -> pkt_valid=0, data_out=0x00 asynchronously; then re-run REQ-031 passes.

Source files
------------

// File: rtl/router_pkt_src.sv
// Packet source for the router: buffers payload bytes, then emits
// header, payload and parity under router busy back-pressure.
module router_pkt_src #(
   parameter int BUF_AW = 6
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pl_wr,
   input  logic [7:0] pl_data,
   output logic       load_ready,
   input  logic       start,
   input  logic [1:0] dest,
   input  logic [5:0] len,
   input  logic       corrupt_parity,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic       tx_active,
   output logic       done,
   output logic       start_err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HEADER  = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [1:0] S_PARITY  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic              done_q, done_d;
   logic              start_err_q, start_err_d;
   logic [BUF_AW-1:0] count_q, count_d;
   logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [5:0]        len_q, len_d;
   logic              corrupt_q, corrupt_d;
   logic [7:0]        parity_q, parity_d;
   logic              wr_en;
   logic [7:0]        mem_q [0:(1<<BUF_AW)-1];

   assign load_ready = (state_q == S_IDLE) && (count_q != '1);
   assign tx_active  = (state_q != S_IDLE);
   assign pkt_valid  = pkt_valid_q;
   assign data_out   = data_out_q;
   assign done       = done_q;
   assign start_err  = start_err_q;

   always_comb begin
      state_d     = state_q;
      data_out_d  = data_out_q;
      pkt_valid_d = pkt_valid_q;
      done_d      = 1'b0;
      start_err_d = 1'b0;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      corrupt_d   = corrupt_q;
      parity_d    = parity_q;
      wr_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pl_wr && load_ready) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
            end
            if (start) begin
               if (dest == 2'b11 || len > count_q) begin
                  start_err_d = 1'b1;
               end else begin
                  state_d     = S_HEADER;
                  data_out_d  = {len, dest};
                  pkt_valid_d = 1'b1;
                  parity_d    = {len, dest};
                  len_d       = len;
                  corrupt_d   = corrupt_parity;
                  rd_ptr_d    = '0;
               end
            end
         end
         // Header and payload share one path: rd_ptr is 0 after the header,
         // so len==0 falls straight through to the parity byte.
         S_HEADER, S_PAYLOAD: begin
            if (!busy) begin
               if (rd_ptr_q == len_q) begin
                  state_d     = S_PARITY;
                  pkt_valid_d = 1'b0;
                  data_out_d  = parity_q ^ {7'b0, corrupt_q};
               end else begin
                  state_d    = S_PAYLOAD;
                  data_out_d = mem_q[rd_ptr_q];
                  parity_d   = parity_q ^ mem_q[rd_ptr_q];
                  rd_ptr_d   = rd_ptr_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               state_d    = S_IDLE;
               done_d     = 1'b1;
               data_out_d = '0;
               count_d    = '0;
               rd_ptr_d   = '0;
               parity_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         data_out_q  <= '0;
         pkt_valid_q <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         corrupt_q   <= 1'b0;
         parity_q    <= '0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         pkt_valid_q <= pkt_valid_d;
         done_q      <= done_d;
         start_err_q <= start_err_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         corrupt_q   <= corrupt_d;
         parity_q    <= parity_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[count_q] <= pl_data;
   end

endmodule

// File: tb/tb_router_pkt_src.sv
// Scoreboard bench for router_pkt_src: stimulus pushes expected bytes and
// pulses, a negedge monitor pops and compares what the DUT presents.
module tb_router_pkt_src;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pl_wr = 1'b0;
   logic [7:0] pl_data = '0;
   logic       load_ready;
   logic       start = 1'b0;
   logic [1:0] dest = '0;
   logic [5:0] len = '0;
   logic       corrupt_parity = 1'b0;
   logic       busy = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_active;
   logic       done;
   logic       start_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] kind;   // 0 byte, 1 done, 2 start_err
      logic       pv;
      logic [7:0] d;
   } exp_t;
   exp_t sb[$];

   logic [7:0] pl_bytes [0:4];

   router_pkt_src #(.BUF_AW(6)) dut (
      .clock(clock), .resetn(resetn), .pl_wr(pl_wr), .pl_data(pl_data),
      .load_ready(load_ready), .start(start), .dest(dest), .len(len),
      .corrupt_parity(corrupt_parity), .busy(busy), .pkt_valid(pkt_valid),
      .data_out(data_out), .tx_active(tx_active), .done(done),
      .start_err(start_err)
   );

   always #5 clock = ~clock;

   task automatic push(input logic [1:0] k, input logic pv, input logic [7:0] d);
      exp_t e;
      e.kind = k; e.pv = pv; e.d = d;
      sb.push_back(e);
   endtask

   task automatic sb_check(input logic [1:0] k, input logic pv, input logic [7:0] d);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_output kind=%0d pv=%0b data=%02h, nothing expected", k, pv, d);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.pv != pv || e.d != d) begin
            errors++;
            $display("FAIL sb_output got kind=%0d pv=%0b data=%02h, expected kind=%0d pv=%0b data=%02h",
                     k, pv, d, e.kind, e.pv, e.d);
         end
      end
   endtask

   task automatic expect_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: a byte is consumed when presented with busy low at the next rising edge.
   always @(negedge clock) begin
      if (resetn) begin
         if (tx_active && !busy) sb_check(2'd0, pkt_valid, data_out);
         if (done)               sb_check(2'd1, 1'b0, 8'h00);
         if (start_err)          sb_check(2'd2, 1'b0, 8'h00);
      end
   end

   task automatic load_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         expect_eq("load_ready", int'(load_ready), 1);
         pl_wr = 1'b1;
         pl_data = pl_bytes[i];
         @(posedge clock); #1;
      end
      pl_wr = 1'b0;
   endtask

   task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input logic cp,
                          input logic [7:0] hdr, input logic [7:0] par,
                          input logic [7:0] stall_byte, input int stall_n,
                          input int exp_cycles, input string name);
      int cyc;
      int st;
      push(2'd0, 1'b1, hdr);
      for (int i = 0; i < int'(l); i++) push(2'd0, 1'b1, pl_bytes[i]);
      push(2'd0, 1'b0, par);
      push(2'd1, 1'b0, 8'h00);
      dest = d; len = l; corrupt_parity = cp; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cyc = 0;
      st = stall_n;
      while (!done && cyc < 100) begin
         if (st > 0 && pkt_valid && data_out == stall_byte && tx_active) begin
            busy = 1'b1;
            repeat (st) begin @(posedge clock); #1; cyc++; end
            busy = 1'b0;
            st = 0;
         end else begin
            @(posedge clock); #1; cyc++;
         end
      end
      expect_eq(name, cyc, exp_cycles);
      @(posedge clock); #1;
   endtask

   task automatic reject(input logic [1:0] d, input logic [5:0] l, input string name);
      push(2'd2, 1'b0, 8'h00);
      dest = d; len = l; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      expect_eq(name, int'(start_err), 1);
      expect_eq({name, "_pv"}, int'(pkt_valid), 0);
      expect_eq({name, "_tx"}, int'(tx_active), 0);
      @(posedge clock); #1;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) pl_bytes[i] = 8'(i + 1);

      repeat (2) @(posedge clock);
      #1;
      expect_eq("rst_pkt_valid", int'(pkt_valid), 0);
      expect_eq("rst_data_out", int'(data_out), 0);
      expect_eq("rst_tx_active", int'(tx_active), 0);
      expect_eq("rst_done", int'(done), 0);
      resetn = 1'b1;
      @(posedge clock); #1;
      expect_eq("idle_load_ready", int'(load_ready), 1);

      load_bytes(5);
      run_pkt(2'd2, 6'd5, 1'b0, 8'h16, 8'h17, 8'h00, 0, 7, "basic_cycles");

      load_bytes(5);
      run_pkt(2'd2, 6'd5, 1'b0, 8'h16, 8'h17, 8'h03, 3, 10, "stall_cycles");

      run_pkt(2'd1, 6'd0, 1'b0, 8'h01, 8'h01, 8'h00, 0, 2, "zero_len_cycles");

      load_bytes(5);
      run_pkt(2'd2, 6'd5, 1'b1, 8'h16, 8'h16, 8'h00, 0, 7, "corrupt_cycles");

      load_bytes(2);
      reject(2'd0, 6'd5, "err_len");
      reject(2'd3, 6'd0, "err_dest");

      // Reset while byte 02 is presented; buffer leftovers are discarded too.
      resetn = 1'b0;
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      load_bytes(5);
      push(2'd0, 1'b1, 8'h16);
      push(2'd0, 1'b1, 8'h01);
      dest = 2'd2; len = 6'd5; corrupt_parity = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int i = 0; i < 20 && !(pkt_valid && data_out == 8'h02); i++) begin
         @(posedge clock); #1;
      end
      expect_eq("mid_byte02", int'(data_out), 8'h02);
      #1;
      resetn = 1'b0;
      #1;
      expect_eq("async_rst_pv", int'(pkt_valid), 0);
      expect_eq("async_rst_data", int'(data_out), 0);
      expect_eq("async_rst_tx", int'(tx_active), 0);
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;

      load_bytes(5);
      run_pkt(2'd2, 6'd5, 1'b0, 8'h16, 8'h17, 8'h00, 0, 7, "post_rst_cycles");

      repeat (2) @(posedge clock);
      #1;
      expect_eq("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
